// File: rtl/ap_ctrl_pkg.sv
// Shared types and helpers for the ap_ctrl handshake sequencer.
package ap_ctrl_pkg;

    localparam int CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        TOUT  = 3'd4
    } seq_state_e;

    // Modular difference keeps latency correct across a timestamp wrap.
    function automatic cnt_t lat_calc(input cnt_t now_v, input cnt_t ts_v);
        return now_v - ts_v;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ap_ts_fifo.sv
// Start-timestamp FIFO: first-word-fall-through, simultaneous push/pop, flush.
module ap_ts_fifo
    import ap_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  cnt_t                     wr_data,
    output cnt_t                     rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT1_C = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR1_C = AW'(1'b1);

    cnt_t          mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full    = (count_r == FULL_C);
    assign empty   = (count_r == {(AW+1){1'b0}});
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Qualify requests; a push into a full FIFO is legal only alongside a pop.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {CNT_W{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR1_C;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR1_C;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT1_C;
                2'b01:   count_r <= count_r - CNT1_C;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Initiator side of the ap_ctrl_hs / ap_ctrl_chain block handshake with latency capture.
// Define AP_CTRL_CHAIN_EN for ap_ctrl_chain (hold drives ap_continue); default is ap_ctrl_hs.
module ap_ctrl_sequencer
    import ap_ctrl_pkg::*;
#(
    parameter int   NUM_TRANS   = 10,
    parameter int   OUTST_MAX   = 4,
    parameter int   TIMEOUT_CYC = 100000,
    parameter cnt_t TS_INIT     = {CNT_W{1'b0}}
) (
    input  logic clock,
    input  logic reset,
    input  logic go,
    input  logic hold,
    output logic ap_start,
    output logic ap_continue,
    input  logic ap_ready,
    input  logic ap_done,
    output logic busy,
    output logic finish,
    output logic timeout_err,
    output cnt_t start_cnt,
    output cnt_t done_cnt,
    output cnt_t last_lat,
    output cnt_t max_lat
);
    localparam int          AW     = $clog2(OUTST_MAX);
    localparam cnt_t        ZERO_C = {CNT_W{1'b0}};
    localparam cnt_t        ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam cnt_t        N_C    = cnt_t'(NUM_TRANS);
    localparam cnt_t        TO_C   = cnt_t'(TIMEOUT_CYC - 1);
    localparam logic [AW:0] OM_C   = (AW+1)'(OUTST_MAX);
    localparam logic [AW:0] CNT1_C = (AW+1)'(1'b1);

    seq_state_e  state_r, state_s;
    cnt_t        now_r, idle_r, idle_s;
    cnt_t        start_cnt_r, start_cnt_s, done_cnt_r, done_cnt_s;
    cnt_t        last_lat_r, last_lat_s, max_lat_r, max_lat_s;
    logic        ap_start_r, ap_start_s, busy_r, finish_r;
    logic        timeout_err_r, timeout_err_s;
    logic        flush_s, push_s, pop_s;
    logic        accept_s, complete_s, progress_s;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count, cnt_nxt_s;
    cnt_t        fifo_rd, lat_s;

`ifdef AP_CTRL_CHAIN_EN
    assign ap_continue = ~hold & busy_r;
`else
    logic unused_hold_s;
    assign unused_hold_s = hold;
    assign ap_continue   = 1'b1;
`endif

    assign accept_s   = ap_start_r & ap_ready;
    assign complete_s = ap_done & ap_continue;
    assign progress_s = accept_s | complete_s;
    assign lat_s      = lat_calc(now_r, fifo_rd);

    ap_ts_fifo #(.DEPTH(OUTST_MAX)) u_ts_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush_s),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (now_r),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next state, counter updates and start request.
    always_comb begin
        state_s       = state_r;
        start_cnt_s   = start_cnt_r;
        done_cnt_s    = done_cnt_r;
        last_lat_s    = last_lat_r;
        max_lat_s     = max_lat_r;
        idle_s        = idle_r;
        timeout_err_s = timeout_err_r;
        flush_s       = 1'b0;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        cnt_nxt_s     = fifo_count;
        ap_start_s    = 1'b0;
        case (state_r)
            IDLE, DONE, TOUT: begin
                if (go) begin
                    state_s       = RUN;
                    start_cnt_s   = ZERO_C;
                    done_cnt_s    = ZERO_C;
                    max_lat_s     = ZERO_C;
                    idle_s        = ZERO_C;
                    timeout_err_s = 1'b0;
                    flush_s       = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            RUN, DRAIN: begin
                // A done with nothing outstanding is a protocol error, handled like a timeout.
                if ((complete_s && fifo_empty) || (!progress_s && (idle_r == TO_C))) begin
                    state_s       = TOUT;
                    timeout_err_s = 1'b1;
                    flush_s       = 1'b1;
                end else begin
                    push_s = accept_s;
                    pop_s  = complete_s;
                    idle_s = progress_s ? ZERO_C : sat_inc(idle_r);
                    if (accept_s) begin
                        start_cnt_s = start_cnt_r + ONE_C;
                    end else begin
                        start_cnt_s = start_cnt_r;
                    end
                    if (complete_s) begin
                        done_cnt_s = done_cnt_r + ONE_C;
                        last_lat_s = lat_s;
                        max_lat_s  = (lat_s > max_lat_r) ? lat_s : max_lat_r;
                    end else begin
                        done_cnt_s = done_cnt_r;
                    end
                    if (done_cnt_s == N_C) begin
                        state_s = DONE;
                    end else if (start_cnt_s == N_C) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = RUN;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                flush_s = 1'b1;
            end
        endcase
        if (push_s && !pop_s) begin
            cnt_nxt_s = fifo_count + CNT1_C;
        end else if (pop_s && !push_s) begin
            cnt_nxt_s = fifo_count - CNT1_C;
        end else begin
            cnt_nxt_s = fifo_count;
        end
        ap_start_s = (state_r == RUN) && (state_s == RUN) && (cnt_nxt_s < OM_C);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            now_r         <= TS_INIT;
            idle_r        <= ZERO_C;
            start_cnt_r   <= ZERO_C;
            done_cnt_r    <= ZERO_C;
            last_lat_r    <= ZERO_C;
            max_lat_r     <= ZERO_C;
            ap_start_r    <= 1'b0;
            busy_r        <= 1'b0;
            finish_r      <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            now_r         <= now_r + ONE_C;
            idle_r        <= idle_s;
            start_cnt_r   <= start_cnt_s;
            done_cnt_r    <= done_cnt_s;
            last_lat_r    <= last_lat_s;
            max_lat_r     <= max_lat_s;
            ap_start_r    <= ap_start_s;
            busy_r        <= (state_s == RUN) || (state_s == DRAIN);
            finish_r      <= (state_s == DONE) || (state_s == TOUT);
            timeout_err_r <= timeout_err_s;
        end
    end

    assign ap_start    = ap_start_r;
    assign busy        = busy_r;
    assign finish      = finish_r;
    assign timeout_err = timeout_err_r;
    assign start_cnt   = start_cnt_r;
    assign done_cnt    = done_cnt_r;
    assign last_lat    = last_lat_r;
    assign max_lat     = max_lat_r;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Bench for ap_ctrl_sequencer: a simple HLS-kernel responder plus a queue-based reference model.
module tb_ap_ctrl_sequencer;
    localparam int          N   = 3;
    localparam int          OM  = 2;
    localparam int          TO  = 50;
    localparam logic [31:0] TS0 = 32'hFFFF_FFF8;
`ifdef AP_CTRL_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, go, hold, ap_ready, ap_done;
    logic        ap_start, ap_continue, busy, finish, timeout_err;
    logic [31:0] start_cnt, done_cnt, last_lat, max_lat;

    int tests = 0;
    int failed = 0;

    // responder configuration and state
    int ready_mode = 1;
    int hold_mode  = 0;
    int lat_lo     = 1;
    int lat_hi     = 1;
    int start_age  = 0;
    int cyc        = 0;
    bit inject     = 1'b0;
    int rq[$];

    // reference model
    logic        m_busy, m_fin, m_terr, m_start;
    logic [31:0] m_sc, m_dc, m_last, m_max, m_now;
    int          m_idle;
    logic [31:0] mq[$];

    ap_ctrl_sequencer #(
        .NUM_TRANS(N), .OUTST_MAX(OM), .TIMEOUT_CYC(TO), .TS_INIT(TS0)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .hold(hold),
        .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_ready(ap_ready), .ap_done(ap_done),
        .busy(busy), .finish(finish), .timeout_err(timeout_err),
        .start_cnt(start_cnt), .done_cnt(done_cnt),
        .last_lat(last_lat), .max_lat(max_lat)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ap_start", {31'd0, ap_start}, {31'd0, m_start});
        chk("ap_continue", {31'd0, ap_continue}, {31'd0, CHAIN ? (!hold && m_busy) : 1'b1});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("finish", {31'd0, finish}, {31'd0, m_fin});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
        chk("start_cnt", start_cnt, m_sc);
        chk("done_cnt", done_cnt, m_dc);
        chk("last_lat", last_lat, m_last);
        chk("max_lat", max_lat, m_max);
    endtask

    task automatic do_reset();
        reset = 1'b1; go = 1'b0; hold = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; inject = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        m_busy = 1'b0; m_fin = 1'b0; m_terr = 1'b0; m_start = 1'b0;
        m_sc = 32'd0; m_dc = 32'd0; m_last = 32'd0; m_max = 32'd0;
        m_now = TS0; m_idle = 0; mq.delete(); rq.delete(); start_age = 0;
        check_all();
    endtask

    // One clock: drive inputs, advance the model by the spec rules, compare after the edge.
    task automatic step(input logic go_v);
        logic        acc, cont, cmp, bad;
        logic [31:0] lat;
        go = go_v;
        case (ready_mode)
            0:       ap_ready = ($urandom_range(0, 1) == 1);
            1:       ap_ready = 1'b1;
            2:       ap_ready = 1'b0;
            default: ap_ready = m_start && (start_age >= 1);
        endcase
        case (hold_mode)
            1:       hold = ($urandom_range(0, 3) == 0);
            2:       hold = 1'b1;
            default: hold = 1'b0;
        endcase
        ap_done = inject || ((rq.size() > 0) && (rq[0] <= cyc));
        acc  = m_start && ap_ready;
        cont = CHAIN ? (!hold && m_busy) : 1'b1;
        cmp  = ap_done && cont;
        if (cmp && (rq.size() > 0)) void'(rq.pop_front());
        if (acc) rq.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
        start_age = (m_start && !acc) ? start_age + 1 : 0;
        if (!m_busy) begin
            if (go_v) begin
                m_busy = 1'b1; m_fin = 1'b0; m_terr = 1'b0;
                m_sc = 32'd0; m_dc = 32'd0; m_max = 32'd0; m_idle = 0; mq.delete();
            end
            m_start = 1'b0;
        end else begin
            bad = (cmp && (mq.size() == 0)) || (!acc && !cmp && (m_idle + 1 == TO));
            if (bad) begin
                m_busy = 1'b0; m_fin = 1'b1; m_terr = 1'b1; m_start = 1'b0;
                mq.delete(); rq.delete();
            end else begin
                m_idle = (acc || cmp) ? 0 : m_idle + 1;
                if (cmp) begin
                    lat = m_now - mq.pop_front();
                    m_last = lat;
                    if (lat > m_max) m_max = lat;
                    m_dc = m_dc + 32'd1;
                end
                if (acc) begin
                    mq.push_back(m_now);
                    m_sc = m_sc + 32'd1;
                end
                if (m_dc == N) begin
                    m_busy = 1'b0; m_fin = 1'b1; m_start = 1'b0;
                end else begin
                    m_start = (m_sc < N) && (mq.size() < OM);
                end
            end
        end
        m_now = m_now + 32'd1;
        cyc++;
        @(posedge clock);
        #1;
        check_all();
    endtask

    // Pulse go, then clock until the model says the run ended (bounded).
    task automatic run_to_end(input bit rand_go, output int hi);
        hi = 0;
        step(1'b1);
        for (int i = 0; i < 400 && m_busy; i++) begin
            step(rand_go ? ($urandom_range(0, 7) == 0) : 1'b0);
            if (ap_start === 1'b1) hi++;
        end
        chk("run_end_finish", {31'd0, finish}, 32'd1);
    endtask

    initial begin
        int hi;
        do_reset();

        // ready one cycle after start, latency 5, timestamps wrap during this run
        ready_mode = 3; lat_lo = 5; lat_hi = 5;
        run_to_end(1'b0, hi);
        chk("t1_start_cnt", start_cnt, 32'd3);
        chk("t1_done_cnt", done_cnt, 32'd3);
        chk("t1_wrap_lat", last_lat, 32'd5);
        chk("t1_max_lat", max_lat, 32'd5);

        // ready tied high, done every cycle: three back-to-back accepts
        ready_mode = 1; lat_lo = 1; lat_hi = 1;
        run_to_end(1'b0, hi);
        chk("t2_start_high_cycles", hi, 32'd3);
        chk("t2_last_lat", last_lat, 32'd1);

        // long latency: start held low once OUTST_MAX are outstanding
        lat_lo = 20; lat_hi = 20;
        step(1'b1);
        repeat (6) step(1'b0);
        chk("t3_start_held_low", {31'd0, ap_start}, 32'd0);
        chk("t3_two_accepts", start_cnt, 32'd2);
        for (int i = 0; i < 200 && m_busy; i++) step(1'b0);
        chk("t3_max_lat", max_lat, 32'd20);

        // never ready: timeout
        ready_mode = 2;
        run_to_end(1'b0, hi);
        chk("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
        chk("t4_start_high_cycles", hi, 32'd49);
        chk("t4_start_cnt", start_cnt, 32'd0);

        // done with nothing outstanding: protocol error
        step(1'b1);
        step(1'b0);
        inject = 1'b1;
        step(1'b0);
        inject = 1'b0;
        chk("t5_proto_err", {31'd0, timeout_err}, 32'd1);
        chk("t5_proto_finish", {31'd0, finish}, 32'd1);

`ifdef AP_CTRL_CHAIN_EN
        // hold blocks done consumption
        ready_mode = 1; lat_lo = 3; lat_hi = 3;
        step(1'b1);
        step(1'b0);
        hold_mode = 2;
        repeat (10) step(1'b0);
        chk("t6_done_held", done_cnt, 32'd0);
        hold_mode = 0;
        for (int i = 0; i < 200 && m_busy; i++) step(1'b0);
        chk("t6_done_after_hold", done_cnt, 32'd3);
        hold_mode = 1;
`endif

        // randomized runs with stray go pulses while busy
        ready_mode = 0; lat_lo = 1; lat_hi = 8;
        for (int r = 0; r < 6; r++) begin
            run_to_end(1'b1, hi);
            chk("rand_done_cnt", done_cnt, 32'd3);
        end

        // reset in the middle of a run
        hold_mode = 0;
        step(1'b1);
        repeat (4) step(1'b0);
        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        ready_mode = 3; lat_lo = 2; lat_hi = 6;
        run_to_end(1'b0, hi);
        chk("post_rst_done", done_cnt, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
